reaction_delay_timer: RTL and testbench

- Consumes the free-running N-bit LFSR value and turns it into a random wait before the "GO" stimulus of the reaction-time test.
- On start: latches the random word and scales it to a millisecond delay. Counts the delay down on a millisecond tick, then asserts GO.
- Reports either a valid response or a false start (button pressed before GO) to the top-level game FSM and display logic.

---
 rtl/reaction_delay_timer.sv | 155 +++++++++++++++
 tb/tb_reaction_delay_timer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/reaction_delay_timer.sv
// Random-delay GO generator for the reaction-time game: IDLE -> WAIT (ms countdown) -> GO.
// Optional reaction measurement/timeout enabled by REACTION_DELAY_TIMER_MEASURE_EN.
module reaction_delay_timer #(
  parameter int N           = 8,
  parameter int TICK_CYCLES = 50000,
  parameter int MIN_MS      = 1000,
  parameter int STEP_MS     = 8,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_MS  = 9999
) (
  input  logic             clk,
  input  logic             iReset,
  input  logic [N-1:0]     iRandom,
  input  logic             iStart,
  input  logic             iButton,
  output logic             oBusy,
  output logic             oGo,
  output logic             oDone,
  output logic             oFalseStart,
  output logic [CNT_W-1:0] oDelayMs,
  output logic [CNT_W-1:0] oReactionMs,
  output logic             oTimeout
);

  localparam int PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);
  localparam longint MAX_D = longint'(MIN_MS) + ((longint'(1) << N) - 1) * longint'(STEP_MS);

  if (MAX_D >= (longint'(1) << CNT_W)) begin : g_bad_delay_range
    $error("reaction_delay_timer: MIN_MS + (2^N-1)*STEP_MS does not fit in CNT_W bits");
  end
  if (longint'(TIMEOUT_MS) >= (longint'(1) << CNT_W)) begin : g_bad_timeout
    $error("reaction_delay_timer: TIMEOUT_MS does not fit in CNT_W bits");
  end

  typedef enum logic [1:0] {IDLE, WAIT, GO} state_e;

  state_e             state_q, state_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic               go_q, go_d;
  logic               done_q, done_d;
  logic               fs_q, fs_d;
  logic [CNT_W-1:0]   dly_q, dly_d;
  logic               tick;
  logic               to_hit;
  logic [CNT_W-1:0]   delay_w;

  assign tick    = (pre_q == PRE_LAST);
  assign delay_w = CNT_W'(MIN_MS) + CNT_W'(iRandom) * CNT_W'(STEP_MS);

`ifdef REACTION_DELAY_TIMER_MEASURE_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] react_q, react_d;
  logic             tout_q, tout_d;

  // Timeout fires on the tick that would bring the count to TIMEOUT_MS.
  assign to_hit = tick && (cnt_q == CNT_W'(TIMEOUT_MS - 1));

  always_comb begin
    cnt_d   = '0;
    react_d = react_q;
    tout_d  = 1'b0;
    if (state_q == GO) begin
      cnt_d = tick ? cnt_q + CNT_W'(1) : cnt_q;
      if (iButton) begin
        react_d = cnt_q;
      end else if (to_hit) begin
        react_d = CNT_W'(TIMEOUT_MS);
        tout_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (iReset) begin
      cnt_q   <= '0;
      react_q <= '0;
      tout_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      react_q <= react_d;
      tout_q  <= tout_d;
    end
  end

  assign oReactionMs = react_q;
  assign oTimeout    = tout_q;
`else
  assign to_hit      = 1'b0;
  assign oReactionMs = '0;
  assign oTimeout    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (iReset) begin
      state_q <= IDLE;
      pre_q   <= '0;
      rem_q   <= '0;
      go_q    <= 1'b0;
      done_q  <= 1'b0;
      fs_q    <= 1'b0;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      rem_q   <= rem_d;
      go_q    <= go_d;
      done_q  <= done_d;
      fs_q    <= fs_d;
      dly_q   <= dly_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (iStart) begin
          state_d = WAIT;
          pre_d   = '0;
          rem_d   = delay_w;
        end
      end
      WAIT: begin
        pre_d = tick ? '0 : pre_q + PRE_W'(1);
        if (tick) rem_d = rem_q - CNT_W'(1);
        // A press on the final tick still counts as a false start.
        if (iButton)                       state_d = IDLE;
        else if (tick && rem_q == CNT_W'(1)) state_d = GO;
      end
      GO: begin
        pre_d = tick ? '0 : pre_q + PRE_W'(1);
        if (iButton || to_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    go_d   = (state_d == GO);
    done_d = (state_q == GO) && iButton;
    fs_d   = (state_q == WAIT) && iButton;
    dly_d  = ((state_q == IDLE) && iStart) ? delay_w : dly_q;
  end

  assign oBusy       = (state_q != IDLE);
  assign oGo         = go_q;
  assign oDone       = done_q;
  assign oFalseStart = fs_q;
  assign oDelayMs    = dly_q;

endmodule

// File: tb/tb_reaction_delay_timer.sv
// Directed + randomized bench for reaction_delay_timer with scaled-down sim timing.
module tb_reaction_delay_timer;
  localparam int N = 8, TICK = 4, MIN = 10, STEP = 2, CW = 16, TO = 50;

  logic          clk = 0;
  logic          iReset = 1;
  logic [N-1:0]  iRandom = '0;
  logic          iStart = 0, iButton = 0;
  logic          oBusy, oGo, oDone, oFalseStart, oTimeout;
  logic [CW-1:0] oDelayMs, oReactionMs;

  int n_pass = 0, n_total = 0;
  int exp_react = 0;

  reaction_delay_timer #(.N(N), .TICK_CYCLES(TICK), .MIN_MS(MIN), .STEP_MS(STEP),
                         .CNT_W(CW), .TIMEOUT_MS(TO)) dut (
    .clk(clk), .iReset(iReset), .iRandom(iRandom), .iStart(iStart), .iButton(iButton),
    .oBusy(oBusy), .oGo(oGo), .oDone(oDone), .oFalseStart(oFalseStart),
    .oDelayMs(oDelayMs), .oReactionMs(oReactionMs), .oTimeout(oTimeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Model: D = MIN + r*STEP ms; GO rises D*TICK edges after the start edge.
  // Press on edge p (counted from start edge): p <= D*TICK is a false start,
  // otherwise a valid response with floor((p-1-D*TICK)/TICK) whole ms elapsed.
  task automatic run_round(input int r, input int p, input bit noise);
    int d, go_at, rise;
    bit stray;
    d = MIN + r * STEP;
    go_at = d * TICK;
    iRandom = N'(r);
    iStart = 1;
    step();
    iStart = 0;
    chk("delay_ms", oDelayMs, d);
    chk("busy_after_start", oBusy, 1);
    rise = 0;
    stray = 0;
    for (int k = 1; k < p; k++) begin
      iStart = noise && ($urandom_range(0, 7) == 0);
      iRandom = N'($urandom);
      step();
      if (oGo && rise == 0) rise = k;
      if (oDone || oFalseStart || oTimeout) stray = 1;
    end
    iStart = 0;
    iButton = 1;
    step();
    iButton = 0;
    if (p <= go_at) begin
      chk("false_start", oFalseStart, 1);
      chk("no_done_on_fs", oDone, 0);
      chk("go_never_rose", rise, 0);
    end else begin
      chk("done", oDone, 1);
      chk("no_fs_on_done", oFalseStart, 0);
      chk("go_rise_cycle", rise, go_at);
`ifdef REACTION_DELAY_TIMER_MEASURE_EN
      exp_react = (p - 1 - go_at) / TICK;
`endif
    end
    chk("reaction_ms", oReactionMs, exp_react);
    chk("go_low_after", oGo, 0);
    chk("idle_after", oBusy, 0);
    chk("no_stray_pulse", stray, 0);
    chk("delay_held", oDelayMs, d);
    step();
    chk("pulse_one_cycle", {oDone, oFalseStart}, 0);
  endtask

  initial begin
    int rise, tout, r;
    bit bad;
    step();
    step();
    chk("rst_go", oGo, 0);
    chk("rst_done", oDone, 0);
    chk("rst_fs", oFalseStart, 0);
    chk("rst_timeout", oTimeout, 0);
    chk("rst_delay", oDelayMs, 0);
    chk("rst_react", oReactionMs, 0);
    chk("rst_busy", oBusy, 0);
    iReset = 0;
    step();

    // Button alone in IDLE is ignored.
    iButton = 1;
    step();
    iButton = 0;
    chk("idle_button_fs", oFalseStart, 0);
    chk("idle_button_busy", oBusy, 0);

    run_round(0, 40 + 3, 0);
`ifdef REACTION_DELAY_TIMER_MEASURE_EN
    run_round(0, 40 + 37, 0);
`endif
    run_round(255, 2080 + 5, 1);
    run_round(5, 30, 0);
    run_round(5, 80, 0);
    run_round(5, 81, 0);

    // Start and button together in IDLE: start wins.
    iRandom = 8'd3;
    iStart = 1;
    iButton = 1;
    step();
    iStart = 0;
    iButton = 0;
    chk("start_btn_fs", oFalseStart, 0);
    chk("start_btn_busy", oBusy, 1);
    chk("start_btn_delay", oDelayMs, 16);
    repeat (10) step();
    iReset = 1;
    step();
    iReset = 0;
    chk("midrst_busy", oBusy, 0);
    chk("midrst_go", oGo, 0);
    chk("midrst_delay", oDelayMs, 0);
    chk("midrst_pulses", {oDone, oFalseStart, oTimeout}, 0);
    exp_react = 0;
    bad = 0;
    repeat (80) begin
      step();
      if (oGo || oBusy || oDone || oFalseStart || oTimeout) bad = 1;
    end
    chk("midrst_quiet", bad, 0);

    // No press after GO.
    iRandom = 8'd0;
    iStart = 1;
    step();
    iStart = 0;
    rise = 0;
    tout = 0;
    bad = 0;
`ifdef REACTION_DELAY_TIMER_MEASURE_EN
    for (int k = 1; k <= 400 && tout == 0; k++) begin
      step();
      if (oGo && rise == 0) rise = k;
      if (oDone) bad = 1;
      if (oTimeout) begin
        tout = k;
        chk("timeout_react", oReactionMs, TO);
        chk("timeout_go", oGo, 0);
        chk("timeout_busy", oBusy, 0);
      end
    end
    chk("timeout_rise", rise, 40);
    chk("timeout_cycle", tout, 40 + TO * TICK);
    chk("timeout_no_done", bad, 0);
    step();
    chk("timeout_one_cycle", oTimeout, 0);
`else
    for (int k = 1; k <= 40 + 10000; k++) begin
      step();
      if (oGo && rise == 0) rise = k;
      if (rise != 0 && !oGo) bad = 1;
      if (oTimeout || oReactionMs != 0 || oDone) tout = 1;
    end
    chk("hold_rise", rise, 40);
    chk("hold_go_stayed", bad, 0);
    chk("hold_no_timeout", tout, 0);
    iButton = 1;
    step();
    iButton = 0;
    chk("hold_done", oDone, 1);
    chk("hold_go_low", oGo, 0);
`endif

    for (int i = 0; i < 6; i++) begin
      r = $urandom_range(0, 120);
      run_round(r, $urandom_range(1, (MIN + r * STEP) * TICK + 40), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
